// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding and packing constants for the instruction-memory loader
package imem_loader_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;
  localparam int LD_BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream load port plus IM write port; master = stream source/IM side, slave = loader
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              ld_start;
  logic [ADDR_W:0]   ld_len;
  logic              ld_byte_valid;
  logic [7:0]        ld_byte;
  logic              ld_byte_ready;
  logic              im_wr_en;
  logic [31:0]       im_wr_addr;
  logic [31:0]       im_wr_data;
  logic              ld_busy;
  logic              ld_done;
  logic              ld_err;
  logic              cpu_hold;
  modport master (
    output ld_start, ld_len, ld_byte_valid, ld_byte,
    input  ld_byte_ready, im_wr_en, im_wr_addr, im_wr_data, ld_busy, ld_done, ld_err, cpu_hold
  );
  modport slave (
    input  ld_start, ld_len, ld_byte_valid, ld_byte,
    output ld_byte_ready, im_wr_en, im_wr_addr, im_wr_data, ld_busy, ld_done, ld_err, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words and writes them sequentially into the IM (clk, async active-low rst_n, bus = slave side of imem_loader_if)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W = 8,
  parameter logic [31:0] BASE   = 32'h0
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);
  state_t          state;
  logic [1:0]      cnt;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] len;
  logic            wr_en;
  logic [31:0]     addr;
  logic [31:0]     data;
  logic            err;
  logic            too_long;
  assign too_long = bus.ld_len[ADDR_W] && |bus.ld_len[ADDR_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      len   <= '0;
      wr_en <= 1'b0;
      addr  <= BASE;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: if (bus.ld_start) begin
          err   <= too_long;
          len   <= bus.ld_len;
          idx   <= '0;
          cnt   <= '0;
          state <= (bus.ld_len == '0 || too_long) ? DONE : COLLECT;
        end
        COLLECT: if (bus.ld_byte_valid) begin
          data[{cnt, 3'b000} +: 8] <= bus.ld_byte;
          cnt <= cnt + 2'd1;
          if (cnt == 2'(LD_BYTES_PER_WORD - 1)) begin
            state <= WRITE;
            wr_en <= 1'b1;
            addr  <= BASE + 32'({idx, 2'b00});
          end
        end
        WRITE: if (idx + 1'b1 == len) state <= DONE;
        else begin
          idx   <= idx + 1'b1;
          state <= COLLECT;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.ld_byte_ready = state == COLLECT;
  assign bus.ld_busy       = state == COLLECT || state == WRITE;
  assign bus.cpu_hold      = bus.ld_busy;
  assign bus.ld_done       = state == DONE;
  assign bus.ld_err        = err;
  assign bus.im_wr_en      = wr_en;
  assign bus.im_wr_addr    = addr;
  assign bus.im_wr_data    = data;
endmodule
